fir_coeff_ctrl: RTL and testbench

Run-time coefficient controller for the transposed-form FIR datapath. Accepts a coefficient stream over a valid/ready handshake into a shadow bank. Swaps shadow and active banks on a sample boundary, then masks filter output validity until the transient is flushed. Sits between the host/config bus and the FIR's coefficient inputs. Also feeds the downstream output-valid qualifier.

---
 rtl/fir_pkg.sv | 38 +++
 rtl/fir_coeff_bank.sv | 39 +++
 rtl/fir_coeff_ctrl.sv | 135 +++++++++++++
 tb/tb_fir_coeff_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and sizing helpers for the FIR coefficient controller.
// FIR_COEFF_SYM_EN selects half-length symmetric loading (word k feeds h[k] and h[TAP-1-k]).
package fir_pkg;

   localparam int unsigned WIDTH_COEFF = 16;
   localparam int unsigned TAP_DEFAULT = 52;

   typedef logic signed [WIDTH_COEFF-1:0] coeff_t;

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StPend,
      StSettle
   } state_e;

   function automatic int unsigned n_load(input int unsigned tap);
`ifdef FIR_COEFF_SYM_EN
      return tap / 2;
`else
      return tap;
`endif
   endfunction

   function automatic int unsigned idx_width(input int unsigned tap);
      return (tap > 1) ? $clog2(tap) : 1;
   endfunction

`ifdef FIR_COEFF_SYM_EN
   localparam bit MIRROR_EN = 1'b1;
`else
   localparam bit MIRROR_EN = 1'b0;
`endif

   localparam int unsigned N_LOAD = n_load(TAP_DEFAULT);
   localparam int unsigned IDX_W  = idx_width(TAP_DEFAULT);

endpackage

// File: rtl/fir_coeff_bank.sv
// One coefficient bank: TAP registers with synchronous clear, single write port
// with optional mirrored write, and a flattened read bus.
module fir_coeff_bank #(
   parameter int unsigned WIDTH_coeff = 16,
   parameter int unsigned TAP         = 52,
   parameter int unsigned AW          = 6
) (
   input  logic                       i_clk,
   input  logic                       i_reset_n,
   input  logic                       i_we,
   input  logic [AW-1:0]              i_addr,
   input  logic                       i_mirror,
   input  logic [WIDTH_coeff-1:0]     i_data,
   output logic [TAP*WIDTH_coeff-1:0] o_coeff
);

   logic [WIDTH_coeff-1:0] r_mem [TAP];
   logic [AW-1:0]          w_maddr;

   assign w_maddr = AW'(TAP - 1) - i_addr;

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         for (int i = 0; i < TAP; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we) begin
         r_mem[i_addr] <= i_data;
         if (i_mirror) begin
            r_mem[w_maddr] <= i_data;
         end
      end
   end

   for (genvar g = 0; g < TAP; g++) begin : g_rd
      assign o_coeff[g*WIDTH_coeff +: WIDTH_coeff] = r_mem[g];
   end

endmodule

// File: rtl/fir_coeff_ctrl.sv
// Double-buffered FIR coefficient controller: streams a set into the shadow bank, swaps on a
// sample strobe, then holds out_valid low for TAP strobes. FIR_COEFF_SYM_EN halves the set.
module fir_coeff_ctrl
   import fir_pkg::*;
#(
   parameter int unsigned WIDTH_coeff = 16,
   parameter int unsigned TAP         = 52
) (
   input  logic                       i_clk,
   input  logic                       i_reset_n,
   input  logic                       i_cfg_valid,
   output logic                       o_cfg_ready,
   input  logic [WIDTH_coeff-1:0]     i_cfg_data,
   input  logic                       i_cfg_last,
   input  logic                       i_sample_stb,
   output logic [TAP*WIDTH_coeff-1:0] o_coeff_out,
   output logic                       o_bank_sel,
   output logic                       o_swap_pulse,
   output logic                       o_out_valid,
   output logic                       o_err_len,
   output logic                       o_busy
);

   localparam int unsigned NLoad = n_load(TAP);
   localparam int unsigned IdxW  = idx_width(TAP);

   state_e                     r_state;
   logic [IdxW-1:0]            r_idx;
   logic [IdxW-1:0]            r_cnt;
   logic                       r_bank_sel;
   logic                       r_swap_pulse;
   logic                       r_out_valid;
   logic                       r_err_len;
   logic                       r_ready_en;
   logic                       w_xfer;
   logic                       w_at_end;
   logic [TAP*WIDTH_coeff-1:0] w_bank0;
   logic [TAP*WIDTH_coeff-1:0] w_bank1;

   // r_ready_en holds ready low for the cycle that follows a reset edge.
   assign o_cfg_ready = r_ready_en && ((r_state == StIdle) || (r_state == StLoad));
   assign w_xfer      = i_cfg_valid && o_cfg_ready;
   assign w_at_end    = (r_idx == IdxW'(NLoad - 1));

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state      <= StIdle;
         r_idx        <= '0;
         r_cnt        <= '0;
         r_bank_sel   <= 1'b0;
         r_swap_pulse <= 1'b0;
         r_out_valid  <= 1'b0;
         r_err_len    <= 1'b0;
         r_ready_en   <= 1'b0;
      end else begin
         r_ready_en   <= 1'b1;
         r_swap_pulse <= 1'b0;
         case (r_state)
            StIdle, StLoad: begin
               if (w_xfer) begin
                  if (i_cfg_last && w_at_end) begin
                     r_state   <= StPend;
                     r_idx     <= '0;
                     r_err_len <= 1'b0;
                  end else if (i_cfg_last || w_at_end) begin
                     r_state   <= StIdle;
                     r_idx     <= '0;
                     r_err_len <= 1'b1;
                  end else begin
                     r_state <= StLoad;
                     r_idx   <= r_idx + 1'b1;
                  end
               end
            end
            StPend: begin
               if (i_sample_stb) begin
                  r_bank_sel   <= ~r_bank_sel;
                  r_swap_pulse <= 1'b1;
                  r_out_valid  <= 1'b0;
                  r_cnt        <= '0;
                  r_state      <= StSettle;
               end
            end
            StSettle: begin
               if (i_sample_stb) begin
                  if (r_cnt == IdxW'(TAP - 1)) begin
                     r_out_valid <= 1'b1;
                     r_state     <= StIdle;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   // The shadow bank is whichever one is not currently active.
   fir_coeff_bank #(
      .WIDTH_coeff (WIDTH_coeff),
      .TAP         (TAP),
      .AW          (IdxW)
   ) u_bank0 (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_we      (w_xfer && r_bank_sel),
      .i_addr    (r_idx),
      .i_mirror  (MIRROR_EN),
      .i_data    (i_cfg_data),
      .o_coeff   (w_bank0)
   );

   fir_coeff_bank #(
      .WIDTH_coeff (WIDTH_coeff),
      .TAP         (TAP),
      .AW          (IdxW)
   ) u_bank1 (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_we      (w_xfer && !r_bank_sel),
      .i_addr    (r_idx),
      .i_mirror  (MIRROR_EN),
      .i_data    (i_cfg_data),
      .o_coeff   (w_bank1)
   );

   assign o_coeff_out  = r_bank_sel ? w_bank1 : w_bank0;
   assign o_bank_sel   = r_bank_sel;
   assign o_swap_pulse = r_swap_pulse;
   assign o_out_valid  = r_out_valid;
   assign o_err_len    = r_err_len;
   assign o_busy       = (r_state != StIdle);

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Bench for fir_coeff_ctrl: random loads against a bank/array reference model, with a
// scoreboard monitor checking every swap pulse and every out_valid rise.
module tb_fir_coeff_ctrl;

   localparam int W   = 16;
   localparam int TAP = 52;
`ifdef FIR_COEFF_SYM_EN
   localparam int NL = TAP / 2;
`else
   localparam int NL = TAP;
`endif

   logic             clk = 1'b0;
   logic             i_reset_n;
   logic             i_cfg_valid;
   logic             o_cfg_ready;
   logic [W-1:0]     i_cfg_data;
   logic             i_cfg_last;
   logic             i_sample_stb;
   logic [TAP*W-1:0] o_coeff_out;
   logic             o_bank_sel;
   logic             o_swap_pulse;
   logic             o_out_valid;
   logic             o_err_len;
   logic             o_busy;

   fir_coeff_ctrl #(
      .WIDTH_coeff (W),
      .TAP         (TAP)
   ) dut (
      .i_clk        (clk),
      .i_reset_n    (i_reset_n),
      .i_cfg_valid  (i_cfg_valid),
      .o_cfg_ready  (o_cfg_ready),
      .i_cfg_data   (i_cfg_data),
      .i_cfg_last   (i_cfg_last),
      .i_sample_stb (i_sample_stb),
      .o_coeff_out  (o_coeff_out),
      .o_bank_sel   (o_bank_sel),
      .o_swap_pulse (o_swap_pulse),
      .o_out_valid  (o_out_valid),
      .o_err_len    (o_err_len),
      .o_busy       (o_busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   // Reference model: two banks of taps, active index, sticky error, settled flag.
   logic [W-1:0] m_bank [2][TAP];
   bit           m_sel;
   bit           m_err;
   bit           m_valid;
   int           m_strobes;
   logic [W-1:0] words [TAP];

   // Scoreboard queues filled by stimulus, drained by the monitor.
   bit               q_swap_sel [$];
   logic [TAP*W-1:0] q_swap_vec [$];
   int               q_valid_cyc [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_vec(input string name, input logic [TAP*W-1:0] act,
                            input logic [TAP*W-1:0] exp);
      bit shown;
      n_checks++;
      shown = 1'b0;
      if (act !== exp) begin
         n_errors++;
         for (int i = 0; i < TAP; i++) begin
            if (!shown && (act[i*W +: W] !== exp[i*W +: W])) begin
               $display("FAIL %s: tap %0d got %0h expected %0h", name, i, act[i*W +: W],
                        exp[i*W +: W]);
               shown = 1'b1;
            end
         end
      end
   endtask

   function automatic logic [TAP*W-1:0] exp_vec(input bit sel);
      logic [TAP*W-1:0] v;
      for (int i = 0; i < TAP; i++) v[i*W +: W] = m_bank[sel][i];
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Monitor: compares each DUT event against the oldest expectation.
   initial begin
      bit prev_valid;
      prev_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (!i_reset_n) begin
            prev_valid = 1'b0;
         end else begin
            if (o_swap_pulse) begin
               if (q_swap_sel.size() == 0) begin
                  check("swap_unexpected", 1, 0);
               end else begin
                  check("swap_bank_sel", o_bank_sel, q_swap_sel.pop_front());
                  check_vec("swap_coeff", o_coeff_out, q_swap_vec.pop_front());
               end
            end
            if (o_out_valid && !prev_valid) begin
               if (q_valid_cyc.size() == 0) check("valid_unexpected", 1, 0);
               else check("valid_rise_cycle", cyc, q_valid_cyc.pop_front());
            end
            prev_valid = o_out_valid;
         end
      end
   end

   task automatic send_word(input logic [W-1:0] d, input bit last, input bit stb);
      int guard;
      guard = 0;
      while (!o_cfg_ready && guard < 200) begin
         tick();
         guard++;
      end
      if (!o_cfg_ready) check("ready_timeout", o_cfg_ready, 1);
      i_cfg_valid  = 1'b1;
      i_cfg_data   = d;
      i_cfg_last   = last;
      i_sample_stb = stb;
      tick();
      i_cfg_valid  = 1'b0;
      i_cfg_last   = 1'b0;
      i_sample_stb = 1'b0;
   endtask

   // Streams words[] until cfg_last, the set length, or max_words, then checks the outcome.
   task automatic load_set(input int last_pos, input int max_words, input bit gaps,
                           input bit stb_last);
      logic [W-1:0] sh [TAP];
      int k;
      int g;
      bit good;
      for (int i = 0; i < TAP; i++) sh[i] = m_bank[!m_sel][i];
      k = 0;
      forever begin
         if (gaps) begin
            g = $urandom_range(0, 2);
            repeat (g) begin
               i_sample_stb = 1'($urandom_range(0, 1));
               tick();
            end
            i_sample_stb = 1'b0;
         end
         send_word(words[k], k == last_pos, stb_last && (k == last_pos));
         sh[k] = words[k];
`ifdef FIR_COEFF_SYM_EN
         sh[TAP-1-k] = words[k];
`endif
         if (k == last_pos || k == NL - 1 || k + 1 == max_words) break;
         k++;
      end
      if (k != last_pos && k != NL - 1) return;
      good = (k == NL - 1) && (last_pos == NL - 1);
      if (good) begin
         for (int i = 0; i < TAP; i++) m_bank[!m_sel][i] = sh[i];
         m_err = 1'b0;
      end else begin
         m_err = 1'b1;
      end
      check("load_err_len", o_err_len, m_err);
      check("load_busy", o_busy, good);
      check("load_ready", o_cfg_ready, !good);
      check("load_swap_quiet", o_swap_pulse, 0);
      check("load_bank_sel", o_bank_sel, m_sel);
      check("load_out_valid", o_out_valid, m_valid);
      check_vec("load_active_kept", o_coeff_out, exp_vec(m_sel));
   endtask

   task automatic do_swap();
      repeat ($urandom_range(0, 3)) tick();
      m_sel     = !m_sel;
      m_valid   = 1'b0;
      m_strobes = 0;
      q_swap_sel.push_back(m_sel);
      q_swap_vec.push_back(exp_vec(m_sel));
      i_sample_stb = 1'b1;
      tick();
      i_sample_stb = 1'b0;
   endtask

   task automatic settle(input int n);
      for (int s = 0; s < n; s++) begin
         repeat ($urandom_range(0, 2)) tick();
         i_sample_stb = 1'b1;
         tick();
         i_sample_stb = 1'b0;
         m_strobes++;
         if (m_strobes == TAP) begin
            m_valid = 1'b1;
            q_valid_cyc.push_back(cyc);
         end
      end
   endtask

   task automatic fill_random();
      for (int i = 0; i < TAP; i++) words[i] = W'($urandom);
   endtask

   task automatic full_cycle(input bit gaps, input bit stb_last);
      fill_random();
      load_set(NL - 1, TAP, gaps, stb_last);
      do_swap();
      settle(TAP);
      check("cycle_out_valid", o_out_valid, 1);
      check("cycle_busy", o_busy, 0);
   endtask

   task automatic apply_reset();
      i_reset_n    = 1'b0;
      i_cfg_valid  = 1'b0;
      i_cfg_last   = 1'b0;
      i_sample_stb = 1'b0;
      tick();
      for (int b = 0; b < 2; b++)
         for (int i = 0; i < TAP; i++) m_bank[b][i] = '0;
      m_sel     = 1'b0;
      m_err     = 1'b0;
      m_valid   = 1'b0;
      m_strobes = 0;
      q_swap_sel.delete();
      q_swap_vec.delete();
      q_valid_cyc.delete();
      check_vec("rst_coeff", o_coeff_out, exp_vec(0));
      check("rst_bank_sel", o_bank_sel, 0);
      check("rst_swap", o_swap_pulse, 0);
      check("rst_out_valid", o_out_valid, 0);
      check("rst_err_len", o_err_len, 0);
      check("rst_ready", o_cfg_ready, 0);
      check("rst_busy", o_busy, 0);
      i_reset_n = 1'b1;
      tick();
   endtask

   initial begin
      i_reset_n    = 1'b0;
      i_cfg_valid  = 1'b0;
      i_cfg_data   = '0;
      i_cfg_last   = 1'b0;
      i_sample_stb = 1'b0;
      tick();
      apply_reset();
      repeat (10) tick();
      check_vec("idle_coeff", o_coeff_out, '0);
      check("idle_out_valid", o_out_valid, 0);
      check("idle_ready", o_cfg_ready, 1);
      check("idle_busy", o_busy, 0);

      // Directed pattern from fixed constants.
      for (int i = 0; i < TAP; i++) begin
`ifdef FIR_COEFF_SYM_EN
         words[i] = W'(16'h0100 + i);
`else
         words[i] = W'(i + 1);
`endif
      end
      load_set(NL - 1, TAP, 1'b0, 1'b0);
      do_swap();
      check("first_bank_sel", o_bank_sel, 1);
`ifdef FIR_COEFF_SYM_EN
      check("sym_h0", o_coeff_out[0 +: W], 16'h0100);
      check("sym_h51", o_coeff_out[51*W +: W], 16'h0100);
      check("sym_h25", o_coeff_out[25*W +: W], 16'h0119);
      check("sym_h26", o_coeff_out[26*W +: W], 16'h0119);
`else
      check("h0", o_coeff_out[0 +: W], 16'h0001);
      check("h51", o_coeff_out[51*W +: W], 16'h0034);
`endif
      settle(TAP - 1);
      check("valid_not_at_51", o_out_valid, 0);
      check("settle_busy", o_busy, 1);
      settle(1);
      check("valid_at_52", o_out_valid, 1);

      // Short set: early cfg_last.
      fill_random();
      load_set(30, TAP, 1'b1, 1'b0);
      // Missing cfg_last on the final word.
      fill_random();
      load_set(-1, TAP, 1'b0, 1'b0);
      // A good set clears err_len; active bank and out_valid hold during the load.
      full_cycle(1'b1, 1'b0);

      // Last word with a simultaneous strobe must not swap.
      fill_random();
      load_set(NL - 1, TAP, 1'b0, 1'b1);
      check("stb_last_no_swap", o_swap_pulse, 0);
      do_swap();
      settle(TAP);

      // Reset mid-load, then a normal cycle.
      fill_random();
      load_set(-1, 20, 1'b1, 1'b0);
      apply_reset();
      full_cycle(1'b1, 1'b0);

      // Reset mid-settle, then a normal cycle.
      fill_random();
      load_set(NL - 1, TAP, 1'b0, 1'b0);
      do_swap();
      settle(10);
      apply_reset();
      full_cycle(1'b0, 1'b0);

      // Random mix of good and malformed sets.
      for (int r = 0; r < 6; r++) begin
         if ($urandom_range(0, 2) == 0) begin
            fill_random();
            load_set(int'($urandom_range(0, NL - 1)) - 1, TAP, 1'b1, 1'b0);
         end else begin
            full_cycle(1'b1, 1'($urandom_range(0, 1)));
         end
      end

      repeat (4) tick();
      check("swap_queue_drained", q_swap_sel.size(), 0);
      check("valid_queue_drained", q_valid_cyc.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
